// File: rtl/cerceve_denetleyici.sv
// cerceve_denetleyici
//   Frame sequencer between the UART RX FIFO, jpeg_coz, gorev_birimi and the
//   TX FIFO. A frame is: length high byte, length low byte (big-endian payload
//   count N), task byte, then N payload bytes. The decoded task is handed to
//   gorev_birimi with a one-cycle start pulse. The payload is streamed into
//   jpeg_coz, and result bytes are forwarded to TX. The frame is closed with
//   the 8-bit modular sum of the result bytes.
//
//   Optional build macro: ZAMAN_ASIMI_EN adds an RX inactivity timeout of
//   ZA_DONGU cycles. The default build has no timer.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rx_veri_i/rx_gecerli_i  RX FIFO head byte / not empty
//   rx_hazir_o              pop RX head (transfer = rx_gecerli_i & rx_hazir_o)
//   coz_veri_o/coz_gecerli_o/coz_hazir_i   payload stream to jpeg_coz
//   gb_basla_o/gb_gorev_o   start pulse and task code to gorev_birimi
//   gb_veri_i/gb_gecerli_i/gb_son_i/gb_stall_o   result stream from gorev_birimi
//   tx_veri_o/tx_gecerli_o/tx_dolu_i       TX FIFO write side
//   mesgul_o                busy (any state but BOSTA)
//   hata_o                  one-cycle error pulse
module cerceve_denetleyici #(
   parameter int VERI_BIT     = 8,
   parameter int UZUNLUK_BIT  = 16,
   parameter int GOREV_BIT    = 2,
   parameter int GOREV_SAYISI = 3,
   parameter int ZA_DONGU     = 1000000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [VERI_BIT-1:0]  rx_veri_i,
   input  logic                 rx_gecerli_i,
   output logic                 rx_hazir_o,
   output logic [VERI_BIT-1:0]  coz_veri_o,
   output logic                 coz_gecerli_o,
   input  logic                 coz_hazir_i,
   output logic                 gb_basla_o,
   output logic [GOREV_BIT-1:0] gb_gorev_o,
   input  logic [VERI_BIT-1:0]  gb_veri_i,
   input  logic                 gb_gecerli_i,
   input  logic                 gb_son_i,
   output logic                 gb_stall_o,
   output logic [VERI_BIT-1:0]  tx_veri_o,
   output logic                 tx_gecerli_o,
   input  logic                 tx_dolu_i,
   output logic                 mesgul_o,
   output logic                 hata_o
);

   typedef enum logic [2:0] {
      BOSTA, UZ_DUSUK, GOREV, BASLAT, AKIT, BEKLE, SAGLAMA, DUSUR
   } durum_t;

   localparam logic [UZUNLUK_BIT-1:0] BIR = UZUNLUK_BIT'(1);

   durum_t                 r_durum, w_sonraki;
   logic [UZUNLUK_BIT-1:0] r_uzunluk;
   logic [UZUNLUK_BIT-1:0] r_sayac;
   logic [VERI_BIT-1:0]    r_toplam;
   logic                   r_son;
   logic [GOREV_BIT-1:0]   r_gorev;

   logic w_rx_aktarim;
   logic w_sonuc_yaz;
   logic w_gorev_gecersiz;
   logic w_zaman_asimi;

   assign w_rx_aktarim     = rx_gecerli_i & rx_hazir_o;
   assign w_sonuc_yaz      = ((r_durum == AKIT) || (r_durum == BEKLE)) &&
                             gb_gecerli_i && !tx_dolu_i;
   assign w_gorev_gecersiz = int'(rx_veri_i[GOREV_BIT-1:0]) >= GOREV_SAYISI;
   assign gb_gorev_o       = r_gorev;
   assign mesgul_o         = (r_durum != BOSTA);

`ifdef ZAMAN_ASIMI_EN
   localparam int ZA_BIT = $clog2(ZA_DONGU + 1);

   logic [ZA_BIT-1:0] r_za;
   logic              w_za_say;

   // In every timed state the RX side is ready except for jpeg_coz stalls in
   // AKIT, so "no byte offered" is the idle condition. This keeps the timer
   // off the rx_hazir_o path and makes coz_hazir_i stalls never time out.
   always_comb begin
      w_za_say = 1'b0;
      case (r_durum)
         UZ_DUSUK, GOREV, AKIT, DUSUR: w_za_say = !rx_gecerli_i;
         default:                      w_za_say = 1'b0;
      endcase
   end

   assign w_zaman_asimi = w_za_say && (r_za == ZA_BIT'(ZA_DONGU - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_za <= '0;
      else if (!w_za_say || w_zaman_asimi)
         r_za <= '0;
      else
         r_za <= r_za + ZA_BIT'(1);
   end
`else
   logic w_unused_za;
   assign w_unused_za   = (ZA_DONGU == 0);
   assign w_zaman_asimi = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_durum   <= BOSTA;
         r_uzunluk <= '0;
         r_sayac   <= '0;
         r_toplam  <= '0;
         r_son     <= 1'b0;
         r_gorev   <= '0;
      end else begin
         r_durum <= w_sonraki;
         case (r_durum)
            BOSTA:
               if (w_rx_aktarim) r_uzunluk <= UZUNLUK_BIT'(rx_veri_i);
            UZ_DUSUK:
               if (w_rx_aktarim)
                  r_uzunluk <= {r_uzunluk[UZUNLUK_BIT-VERI_BIT-1:0], rx_veri_i};
            GOREV:
               if (w_rx_aktarim) begin
                  r_gorev  <= rx_veri_i[GOREV_BIT-1:0];
                  r_sayac  <= r_uzunluk;
                  r_toplam <= '0;
                  r_son    <= 1'b0;
               end
            AKIT, DUSUR:
               if (w_rx_aktarim) r_sayac <= r_sayac - BIR;
            default: ;
         endcase
         // Only active in AKIT/BEKLE, so it never collides with the GOREV clear.
         if (w_sonuc_yaz) begin
            r_toplam <= r_toplam + gb_veri_i;
            if (gb_son_i) r_son <= 1'b1;
         end
      end
   end

   always_comb begin
      w_sonraki     = r_durum;
      rx_hazir_o    = 1'b0;
      coz_veri_o    = '0;
      coz_gecerli_o = 1'b0;
      gb_basla_o    = 1'b0;
      gb_stall_o    = 1'b1;
      tx_veri_o     = '0;
      tx_gecerli_o  = 1'b0;
      hata_o        = 1'b0;

      case (r_durum)
         BOSTA: begin
            rx_hazir_o = 1'b1;
            if (rx_gecerli_i) w_sonraki = UZ_DUSUK;
         end
         UZ_DUSUK: begin
            rx_hazir_o = 1'b1;
            if (rx_gecerli_i) w_sonraki = GOREV;
         end
         GOREV: begin
            rx_hazir_o = 1'b1;
            if (rx_gecerli_i) begin
               if (r_uzunluk == '0) begin
                  hata_o    = 1'b1;
                  w_sonraki = BOSTA;
               end else if (w_gorev_gecersiz) begin
                  hata_o    = 1'b1;
                  w_sonraki = DUSUR;
               end else begin
                  w_sonraki = BASLAT;
               end
            end
         end
         BASLAT: begin
            gb_basla_o = 1'b1;
            w_sonraki  = AKIT;
         end
         AKIT: begin
            coz_veri_o    = rx_veri_i;
            coz_gecerli_o = rx_gecerli_i;
            rx_hazir_o    = coz_hazir_i;
            gb_stall_o    = tx_dolu_i;
            tx_veri_o     = gb_veri_i;
            tx_gecerli_o  = gb_gecerli_i & !tx_dolu_i;
            // The last result may land in the same cycle as the last payload
            // byte; look at the incoming son as well as the stored flag.
            if (rx_gecerli_i && coz_hazir_i && (r_sayac == BIR))
               w_sonraki = (r_son || (w_sonuc_yaz && gb_son_i)) ? SAGLAMA : BEKLE;
         end
         BEKLE: begin
            gb_stall_o   = tx_dolu_i;
            tx_veri_o    = gb_veri_i;
            tx_gecerli_o = gb_gecerli_i & !tx_dolu_i;
            if (w_sonuc_yaz && gb_son_i) w_sonraki = SAGLAMA;
         end
         SAGLAMA: begin
            tx_veri_o    = r_toplam;
            tx_gecerli_o = !tx_dolu_i;
            if (!tx_dolu_i) w_sonraki = BOSTA;
         end
         DUSUR: begin
            rx_hazir_o = 1'b1;
            if (rx_gecerli_i && (r_sayac == BIR)) w_sonraki = BOSTA;
         end
         default: w_sonraki = BOSTA;
      endcase

      if (w_zaman_asimi) begin
         hata_o    = 1'b1;
         w_sonraki = BOSTA;
      end

      // State already sits in BOSTA under reset; keep the FIFO untouched too.
      if (rst_i) rx_hazir_o = 1'b0;
   end

endmodule

// File: tb/tb_cerceve_denetleyici.sv
module tb_cerceve_denetleyici;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_veri_i;
   logic       rx_gecerli_i;
   logic       rx_hazir_o;
   logic [7:0] coz_veri_o;
   logic       coz_gecerli_o;
   logic       coz_hazir_i;
   logic       gb_basla_o;
   logic [1:0] gb_gorev_o;
   logic [7:0] gb_veri_i;
   logic       gb_gecerli_i;
   logic       gb_son_i;
   logic       gb_stall_o;
   logic [7:0] tx_veri_o;
   logic       tx_gecerli_o;
   logic       tx_dolu_i;
   logic       mesgul_o;
   logic       hata_o;

   always #5 clk = ~clk;

   cerceve_denetleyici dut (
      .clk_i(clk), .rst_i(rst),
      .rx_veri_i(rx_veri_i), .rx_gecerli_i(rx_gecerli_i), .rx_hazir_o(rx_hazir_o),
      .coz_veri_o(coz_veri_o), .coz_gecerli_o(coz_gecerli_o), .coz_hazir_i(coz_hazir_i),
      .gb_basla_o(gb_basla_o), .gb_gorev_o(gb_gorev_o),
      .gb_veri_i(gb_veri_i), .gb_gecerli_i(gb_gecerli_i), .gb_son_i(gb_son_i),
      .gb_stall_o(gb_stall_o),
      .tx_veri_o(tx_veri_o), .tx_gecerli_o(tx_gecerli_o), .tx_dolu_i(tx_dolu_i),
      .mesgul_o(mesgul_o), .hata_o(hata_o)
   );

   // Environment queues: RX FIFO content and per-byte tags
   // (0 plain, 1 valid task byte -> start next cycle, 2 task byte -> error now).
   logic [7:0] rxq[$];
   int         rxtag[$];
   logic [7:0] gbq[$];
   bit         gbsonq[$];
   // Expectations from the frame-level model.
   logic [7:0] exp_coz[$];
   logic [7:0] exp_tx[$];
   bit         exp_txck[$];
   logic [1:0] exp_gorev[$];

   int n_chk = 0;
   int n_fail = 0;
   int n_tx = 0;
   int cyc = 0;
   bit gb_aktif = 1'b0;
   bit coz_yavas = 1'b0;
   bit bekle_basla = 1'b0;
   bit bekle_bosta = 1'b0;

   task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
      n_chk++;
      if (gercek !== beklenen) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
      end
   endtask

   task automatic olay_hatasi(input string ad, input logic [31:0] gercek);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %0h expected nothing", ad, gercek);
   endtask

   // Frame checksum: sum of result bytes modulo 256.
   function automatic logic [7:0] saglama(input logic [63:0] b, input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += int'(b[63-8*i -: 8]);
      return 8'(s % 256);
   endfunction

   // Frame-level model: what the RX side carries and what must come out.
   task automatic cerceve(input int uz, input int gorev, input logic [63:0] pl, input int npl,
                          input logic [63:0] sn, input int nsn);
      bit gecerli;
      @(posedge clk); #2;
      gecerli = (uz != 0) && (gorev < 3);
      rxq.push_back(8'(uz >> 8)); rxtag.push_back(0);
      rxq.push_back(8'(uz));      rxtag.push_back(0);
      rxq.push_back(8'(gorev));   rxtag.push_back(gecerli ? 1 : 2);
      for (int i = 0; i < npl; i++) begin
         rxq.push_back(pl[63-8*i -: 8]);
         rxtag.push_back(0);
         if (gecerli) exp_coz.push_back(pl[63-8*i -: 8]);
      end
      if (gecerli) begin
         exp_gorev.push_back(2'(gorev));
         for (int i = 0; i < nsn; i++) begin
            gbq.push_back(sn[63-8*i -: 8]);
            gbsonq.push_back(i == nsn - 1);
            exp_tx.push_back(sn[63-8*i -: 8]);
            exp_txck.push_back(1'b0);
         end
         exp_tx.push_back(saglama(sn, nsn));
         exp_txck.push_back(1'b1);
      end
   endtask

   task automatic bosta_bekle(input string ad);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rxq.size() == 0 && gbq.size() == 0 && exp_tx.size() == 0 && !mesgul_o) && n < 300);
      kontrol({ad, "_tamamlandi"}, (n < 300), 1);
      kontrol({ad, "_coz_kalan"}, exp_coz.size(), 0);
      kontrol({ad, "_gorev_kalan"}, exp_gorev.size(), 0);
   endtask

   // Environment: RX FIFO and gorev_birimi behaviour, driven just after posedge.
   initial begin : ortam
      bit rx_pop, gb_pop;
      rx_gecerli_i = 1'b0; rx_veri_i = '0; coz_hazir_i = 1'b1;
      gb_gecerli_i = 1'b0; gb_veri_i = '0; gb_son_i = 1'b0;
      forever begin
         @(negedge clk);
         rx_pop = rx_gecerli_i && rx_hazir_o;
         gb_pop = gb_gecerli_i && !gb_stall_o;
         if (gb_basla_o) gb_aktif = 1'b1;
         if (rst) gb_aktif = 1'b0;
         @(posedge clk); #1;
         cyc++;
         if (rx_pop && rxq.size() > 0) void'(rxq.pop_front());
         if (gb_pop && gbq.size() > 0) begin
            if (gbsonq.pop_front()) gb_aktif = 1'b0;
            void'(gbq.pop_front());
         end
         rx_gecerli_i = (rxq.size() > 0);
         rx_veri_i    = (rxq.size() > 0) ? rxq[0] : 8'h00;
         gb_gecerli_i = gb_aktif && (gbq.size() > 0);
         gb_veri_i    = gb_gecerli_i ? gbq[0] : 8'h00;
         gb_son_i     = gb_gecerli_i && gbsonq[0];
         coz_hazir_i  = coz_yavas ? (cyc % 2 == 0) : 1'b1;
      end
   end

   // Compare process: every cycle against the model queues.
   always @(negedge clk) begin : karsilastir
      bit rxt;
      int tag;
      rxt = rx_gecerli_i && rx_hazir_o;
      tag = 0;
      if (rxt && rxtag.size() > 0) tag = rxtag.pop_front();

      kontrol("gb_basla", gb_basla_o, bekle_basla);
      bekle_basla = (tag == 1);
      if (gb_basla_o && exp_gorev.size() > 0) kontrol("gb_gorev", gb_gorev_o, exp_gorev.pop_front());
      kontrol("hata", hata_o, (rxt && tag == 2));

      if (coz_gecerli_o && coz_hazir_i) begin
         if (exp_coz.size() == 0) olay_hatasi("coz_fazla", coz_veri_o);
         else kontrol("coz_veri", coz_veri_o, exp_coz.pop_front());
      end

      if (bekle_bosta) kontrol("mesgul_dustu", mesgul_o, 0);
      bekle_bosta = 1'b0;
      if (tx_gecerli_o) begin
         n_tx++;
         if (exp_tx.size() == 0) olay_hatasi("tx_fazla", tx_veri_o);
         else begin
            kontrol("tx_veri", tx_veri_o, exp_tx.pop_front());
            if (exp_txck.pop_front()) begin
               bekle_bosta = 1'b1;
               kontrol("saglama_stall", gb_stall_o, 1);
            end
         end
      end

      if (tx_dolu_i) begin
         kontrol("stall_dolu", gb_stall_o, 1);
         kontrol("tx_yazma_dolu", tx_gecerli_o, 0);
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin : ana
      logic [63:0] v;
      int t0, n;
      rst = 1'b1;
      tx_dolu_i = 1'b0;
      repeat (3) @(negedge clk);

      kontrol("rst_rx_hazir", rx_hazir_o, 0);
      kontrol("rst_gb_stall", gb_stall_o, 1);
      kontrol("rst_mesgul", mesgul_o, 0);
      kontrol("rst_tx_gecerli", tx_gecerli_o, 0);
      kontrol("rst_gb_gorev", gb_gorev_o, 0);
      kontrol("rst_coz_gecerli", coz_gecerli_o, 0);
      rst = 1'b0;

      // Pin the model's checksum with hand-computed values.
      v = 64'h102030_0000000000;
      kontrol("model_saglama_60", saglama(v, 3), 8'h60);
      v = 64'hFFFF02_0000000000;
      kontrol("model_saglama_tasma", saglama(v, 3), 8'h00);

      // Basic frame.
      cerceve(3, 1, 64'hAABBCC_0000000000, 3, 64'h102030_0000000000, 3);
      bosta_bekle("temel");
      kontrol("temel_gorev_tutuldu", gb_gorev_o, 2'd1);

      // Same frame, TX full for 5 cycles right after result 10.
      t0 = n_tx;
      cerceve(3, 1, 64'hAABBCC_0000000000, 3, 64'h102030_0000000000, 3);
      n = 0;
      while (n_tx < t0 + 1 && n < 100) begin @(negedge clk); n++; end
      kontrol("dolu_ilk_yazma", (n < 100), 1);
      @(posedge clk); #1;
      tx_dolu_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      tx_dolu_i = 1'b0;
      bosta_bekle("dolu");
      kontrol("dolu_yazma_sayisi", n_tx - t0, 4);

      // Carry wrap with jpeg_coz back-pressure.
      coz_yavas = 1'b1;
      cerceve(3, 2, 64'h010203_0000000000, 3, 64'hFFFF02_0000000000, 3);
      bosta_bekle("tasma");
      coz_yavas = 1'b0;

      // Invalid task: payload drained, then a valid frame.
      t0 = n_tx;
      cerceve(2, 3, 64'h5566_000000000000, 2, 64'h0, 0);
      bosta_bekle("gecersiz");
      kontrol("gecersiz_tx_yok", n_tx - t0, 0);
      cerceve(1, 0, 64'h77_00000000000000, 1, 64'h5A_00000000000000, 1);
      bosta_bekle("gecersiz_sonrasi");

      // Zero length.
      cerceve(0, 1, 64'h0, 0, 64'h0, 0);
      bosta_bekle("sifir");

      // Reset after the first payload byte.
      cerceve(3, 1, 64'hAA_00000000000000, 1, 64'h0, 0);
      n = 0;
      while ((rxq.size() != 0 || exp_coz.size() != 0) && n < 100) begin @(negedge clk); n++; end
      kontrol("reset_oncesi_akis", (n < 100), 1);
      @(negedge clk);
      kontrol("reset_oncesi_mesgul", mesgul_o, 1);
      rst = 1'b1;
      rxq.delete(); rxtag.delete(); gbq.delete(); gbsonq.delete();
      exp_tx.delete(); exp_txck.delete(); exp_coz.delete(); exp_gorev.delete();
      t0 = n_tx;
      @(negedge clk);
      kontrol("reset_rx_hazir", rx_hazir_o, 0);
      kontrol("reset_coz_gecerli", coz_gecerli_o, 0);
      kontrol("reset_gb_stall", gb_stall_o, 1);
      kontrol("reset_mesgul", mesgul_o, 0);
      kontrol("reset_gb_gorev", gb_gorev_o, 0);
      kontrol("reset_tx_gecerli", tx_gecerli_o, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      kontrol("reset_saglama_yok", n_tx - t0, 0);
      cerceve(3, 2, 64'h112233_0000000000, 3, 64'h010203_0000000000, 3);
      bosta_bekle("reset_sonrasi");

      repeat (3) @(negedge clk);
      kontrol("son_tx_kalan", exp_tx.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
